mdu_iter: RTL and testbench

//  Iterative multiply/divide unit; parametrised, sequential successor to the combinational ALU multiply path.

---
 rtl/mdu_iter_if.sv | 32 +++
 rtl/mdu_iter.sv | 218 +++++++++++++++++++++
 tb/tb_mdu_iter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_if
// Description : Request/response bundle for the iterative multiply/divide unit.
//               The master drives start/op/operands; the slave returns status,
//               result words and NZCV flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_iter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_extra;
   logic [3:0]       flags;

   modport master (
      output start, op, a, b,
      input  busy, done, result, result_extra, flags
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, result_extra, flags
   );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative multiply/divide unit. MUL, UMULL, SMULL by shift-add
//               and UDIV, SDIV by restoring division, one bit per cycle.
//               Signed ops run on magnitudes and are sign-corrected at the end.
//               Latency is data-independent: WIDTH run cycles + FIX + DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter #(
   parameter int WIDTH  = 32,
   parameter int DIV_EN = 1
) (
   input  wire logic  clk,
   input  wire logic  reset,
   mdu_iter_if.slave  bus
);

   localparam int c_CNT_W = $clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   localparam logic [2:0] c_OP_MUL   = 3'b000;
   localparam logic [2:0] c_OP_UDIV  = 3'b010;
   localparam logic [2:0] c_OP_SDIV  = 3'b011;
   localparam logic [2:0] c_OP_SMULL = 3'b110;
   localparam logic [2:0] c_OP_UMULL = 3'b111;

   localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]     r_acc;      // product high word / partial remainder
   logic [WIDTH-1:0]     r_lo;       // multiplier->product low / dividend->quotient
   logic [WIDTH-1:0]     r_opnd;     // multiplicand / divisor magnitude
   logic                 r_is_div;
   logic                 r_is_long;
   logic                 r_undef;
   logic                 r_neg_q;    // negate product or quotient in FIX
   logic                 r_neg_r;    // negate remainder in FIX
   logic                 r_ovf;
   logic                 r_dz;
   logic                 r_busy;
   logic                 r_done;
   logic [WIDTH-1:0]     r_result;
   logic [WIDTH-1:0]     r_extra;
   logic [3:0]           r_flags;

   // Accept-cycle operand decode
   logic                 w_a_neg;
   logic                 w_b_neg;
   logic                 w_is_signed;
   logic                 w_is_div;
   logic                 w_is_long;
   logic                 w_valid;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;

   assign w_a_neg     = bus.a[WIDTH-1];
   assign w_b_neg     = bus.b[WIDTH-1];
   assign w_is_signed = (bus.op == c_OP_SMULL) || (bus.op == c_OP_SDIV);
   assign w_is_div    = (bus.op == c_OP_UDIV) || (bus.op == c_OP_SDIV);
   assign w_is_long   = (bus.op == c_OP_SMULL) || (bus.op == c_OP_UMULL);
   assign w_valid     = (bus.op == c_OP_MUL) || w_is_long || ((DIV_EN != 0) && w_is_div);
   assign w_a_mag     = (w_is_signed && w_a_neg) ? -bus.a : bus.a;
   assign w_b_mag     = (w_is_signed && w_b_neg) ? -bus.b : bus.b;

   // Shift-add multiply step: conditional add, then shift {acc,lo} right
   logic [WIDTH:0]       w_add;
   logic [WIDTH-1:0]     w_mul_acc;
   logic [WIDTH-1:0]     w_mul_lo;

   assign w_add     = r_lo[0] ? ({1'b0, r_acc} + {1'b0, r_opnd}) : {1'b0, r_acc};
   assign w_mul_acc = w_add[WIDTH:1];
   assign w_mul_lo  = {w_add[0], r_lo[WIDTH-1:1]};

   // Restoring divide step: shift in next dividend bit, trial-subtract divisor
   logic [WIDTH-1:0]     w_div_acc;
   logic [WIDTH-1:0]     w_div_lo;

   generate
      if (DIV_EN != 0) begin : g_div
         logic [WIDTH:0]   w_rem_sh;
         logic [WIDTH-1:0] w_diff;
         logic             w_ge;

         assign w_rem_sh  = {r_acc, r_lo[WIDTH-1]};
         assign w_ge      = (w_rem_sh >= {1'b0, r_opnd});
         assign w_diff    = w_rem_sh[WIDTH-1:0] - r_opnd;
         assign w_div_acc = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
         assign w_div_lo  = {r_lo[WIDTH-2:0], w_ge};
      end else begin : g_no_div
         assign w_div_acc = '0;
         assign w_div_lo  = '0;
      end
   endgenerate

   // Final sign correction and flag generation, registered on FIX -> DONE
   logic [2*WIDTH-1:0]   w_full;
   logic [2*WIDTH-1:0]   w_full_fix;
   logic [WIDTH-1:0]     w_q_fix;
   logic [WIDTH-1:0]     w_r_fix;
   logic [WIDTH-1:0]     w_res;
   logic [WIDTH-1:0]     w_ext;
   logic [3:0]           w_flags;

   assign w_full     = {r_acc, r_lo};
   assign w_full_fix = r_neg_q ? -w_full : w_full;
   assign w_q_fix    = r_neg_q ? -r_lo : r_lo;
   assign w_r_fix    = r_neg_r ? -r_acc : r_acc;

   // Select the reported words and build {N,Z,C,V}
   always_comb begin
      w_res   = '0;
      w_ext   = '0;
      w_flags = 4'b0100;
      if (r_undef) begin
         w_res   = '0;
         w_ext   = '0;
         w_flags = 4'b0100;
      end else if (r_is_div) begin
         // Divide by zero reports quotient 0 and the dividend as remainder;
         // the restoring loop already leaves |a| in the remainder register.
         w_res   = r_dz ? '0 : w_q_fix;
         w_ext   = w_r_fix;
         w_flags = {w_res[WIDTH-1], (w_res == '0), 1'b0, r_ovf};
      end else if (r_is_long) begin
         {w_ext, w_res} = w_full_fix;
         w_flags = {w_ext[WIDTH-1], (w_full_fix == '0), 1'b0, 1'b0};
      end else begin
         w_res   = r_lo;
         w_ext   = '0;
         w_flags = {r_lo[WIDTH-1], (r_lo == '0), 1'b0, 1'b0};
      end
   end

   // Control FSM with datapath registers and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_lo      <= '0;
         r_opnd    <= '0;
         r_is_div  <= 1'b0;
         r_is_long <= 1'b0;
         r_undef   <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_ovf     <= 1'b0;
         r_dz      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_extra   <= '0;
         r_flags   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state   <= S_RUN;
                  r_busy    <= 1'b1;
                  r_cnt     <= c_CNT_LAST;
                  r_acc     <= '0;
                  r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
                  r_lo      <= w_is_div ? w_a_mag : w_b_mag;
                  r_is_div  <= w_is_div && w_valid;
                  r_is_long <= w_is_long;
                  r_undef   <= !w_valid;
                  r_neg_q   <= w_is_signed && (w_a_neg ^ w_b_neg);
                  r_neg_r   <= (bus.op == c_OP_SDIV) && w_a_neg;
                  r_ovf     <= (bus.op == c_OP_SDIV) && (bus.a == c_MIN) && (bus.b == '1);
                  r_dz      <= (bus.b == '0);
               end
            end
            S_RUN: begin
               r_acc <= r_is_div ? w_div_acc : w_mul_acc;
               r_lo  <= r_is_div ? w_div_lo  : w_mul_lo;
               if (r_cnt == '0) begin
                  r_state <= S_FIX;
               end else begin
                  r_cnt <= r_cnt - c_CNT_ONE;
               end
            end
            S_FIX: begin
               r_result <= w_res;
               r_extra  <= w_ext;
               r_flags  <= w_flags;
               r_done   <= 1'b1;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.result       = r_result;
   assign bus.result_extra = r_extra;
   assign bus.flags        = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iter
// Description : Scoreboard bench for mdu_iter. A 32-bit full unit and an
//               8-bit unit without divider run side by side; each issued op
//               pushes its expected response, and a per-unit monitor pops and
//               compares on every done pulse, including done latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

   typedef struct {
      logic [31:0] res;
      logic [31:0] ext;
      logic [3:0]  flg;
      int          acc;
      int          lat;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   n_checks;
   int   n_pass;

   exp_t q32[$];
   exp_t q8[$];
   exp_t e32;
   exp_t e8;

   mdu_iter_if #(.WIDTH(32)) bus32 ();
   mdu_iter_if #(.WIDTH(8))  bus8 ();

   mdu_iter #(.WIDTH(32), .DIV_EN(1)) u_dut32 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus32)
   );

   mdu_iter #(.WIDTH(8), .DIV_EN(0)) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   // Clock and cycle counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Monitor for the 32-bit unit
   always @(negedge clk) begin
      if (reset === 1'b1 && bus32.done === 1'b1) begin
         if (q32.size() == 0) begin
            n_checks++;
            $display("FAIL done32_unexpected: got done=1 required no pending op");
         end else begin
            e32 = q32.pop_front();
            check("res32",   bus32.result,       e32.res);
            check("ext32",   bus32.result_extra, e32.ext);
            check("flags32", {28'd0, bus32.flags}, {28'd0, e32.flg});
            check("lat32",   cyc - e32.acc + 1,  e32.lat);
         end
      end
   end

   // Monitor for the 8-bit unit
   always @(negedge clk) begin
      if (reset === 1'b1 && bus8.done === 1'b1) begin
         if (q8.size() == 0) begin
            n_checks++;
            $display("FAIL done8_unexpected: got done=1 required no pending op");
         end else begin
            e8 = q8.pop_front();
            check("res8",   {24'd0, bus8.result},       e8.res);
            check("ext8",   {24'd0, bus8.result_extra}, e8.ext);
            check("flags8", {28'd0, bus8.flags},        {28'd0, e8.flg});
            check("lat8",   cyc - e8.acc + 1,           e8.lat);
         end
      end
   end

   // Wait for the selected unit to be idle, issue one op, queue its expectation.
   // Latency is the number of edges from accept to the edge that samples done.
   task automatic issue(input bit w8, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er,
                        input logic [31:0] ee, input logic [3:0] ef);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while ((w8 ? bus8.busy : bus32.busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         $display("FAIL issue_timeout: got busy=1 required idle within 200 cycles");
         return;
      end
      if (w8) begin
         bus8.start = 1'b1;
         bus8.op    = op;
         bus8.a     = a[7:0];
         bus8.b     = b[7:0];
      end else begin
         bus32.start = 1'b1;
         bus32.op    = op;
         bus32.a     = a;
         bus32.b     = b;
      end
      @(posedge clk);
      #1;
      e.res = er;
      e.ext = ee;
      e.flg = ef;
      e.acc = cyc;
      e.lat = w8 ? 10 : 34;
      if (w8) begin
         q8.push_back(e);
         bus8.start = 1'b0;
         bus8.a     = 8'hA5;
         bus8.b     = 8'h5A;
      end else begin
         q32.push_back(e);
         bus32.start = 1'b0;
         bus32.a     = 32'hDEAD_BEEF;
         bus32.b     = 32'h1234_5678;
      end
      @(negedge clk);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin
      int n;
      n_checks = 0;
      n_pass   = 0;
      cyc      = 0;
      reset    = 1'b0;
      bus32.start = 1'b0; bus32.op = 3'd0; bus32.a = '0; bus32.b = '0;
      bus8.start  = 1'b0; bus8.op  = 3'd0; bus8.a  = '0; bus8.b  = '0;

      repeat (3) @(negedge clk);
      check("rst_busy32",  {31'd0, bus32.busy}, 32'd0);
      check("rst_done32",  {31'd0, bus32.done}, 32'd0);
      check("rst_res32",   bus32.result,        32'd0);
      check("rst_ext32",   bus32.result_extra,  32'd0);
      check("rst_flags32", {28'd0, bus32.flags}, 32'd0);
      check("rst_res8",    {24'd0, bus8.result}, 32'd0);
      reset = 1'b1;

      // Signed/unsigned long multiply and truncating multiply
      issue(0, 3'b110, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFEB, 32'hFFFF_FFFF, 4'b1000);
      issue(0, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1000);
      issue(0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0000);

      // Signed divide, overflow, divide by zero
      issue(0, 3'b011, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000);
      issue(0, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 4'b1001);
      issue(0, 3'b010, 32'd5,         32'd0,        32'h0000_0000, 32'h0000_0005, 4'b0100);

      // Outputs hold during RUN; start while busy is ignored
      issue(0, 3'b010, 32'd100,       32'd7,        32'd14,        32'd2,         4'b0000);
      repeat (4) @(negedge clk);
      check("hold_res32",   bus32.result,         32'd0);
      check("hold_ext32",   bus32.result_extra,   32'd5);
      check("hold_flags32", {28'd0, bus32.flags}, 32'h4);
      bus32.start = 1'b1; bus32.op = 3'b111; bus32.a = 32'd3; bus32.b = 32'd3;
      repeat (2) @(negedge clk);
      bus32.start = 1'b0;

      // Undefined op code
      issue(0, 3'b001, 32'd9,         32'd9,        32'd0,         32'd0,         4'b0100);

      // Reset in the middle of an operation aborts it without a done pulse
      issue(0, 3'b111, 32'd2,         32'd3,        32'd6,         32'd0,         4'b0000);
      repeat (8) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_busy32",  {31'd0, bus32.busy},  32'd0);
      check("abort_res32",   bus32.result,         32'd0);
      check("abort_ext32",   bus32.result_extra,   32'd0);
      check("abort_flags32", {28'd0, bus32.flags}, 32'd0);
      q32.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_nodone_busy32", {31'd0, bus32.busy}, 32'd0);
      issue(0, 3'b110, 32'd5,         32'hFFFF_FFFC, 32'hFFFF_FFEC, 32'hFFFF_FFFF, 4'b1000);

      // 8-bit unit without divider
      issue(1, 3'b111, 32'hFF,        32'hFF,       32'h01,        32'hFE,        4'b1000);
      issue(1, 3'b010, 32'd5,         32'd2,        32'h00,        32'h00,        4'b0100);
      issue(1, 3'b011, 32'hF9,        32'h02,       32'h00,        32'h00,        4'b0100);
      issue(1, 3'b000, 32'h10,        32'h10,       32'h00,        32'h00,        4'b0100);

      // Drain both scoreboards with a bounded wait
      n = 0;
      while ((q32.size() != 0 || q8.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d/%0d pending required 0/0", q32.size(), q8.size());
      end
      repeat (5) @(negedge clk);
      check("final_hold_res32", bus32.result, 32'hFFFF_FFEC);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
